add8_sum_accum: RTL

- Downstream consumer of the combinational 8-bit ripple adder stage. Takes its 8-bit sum outputs (y0..y7 packed LSB-first) as a valid/ready stream.
- Reduces each frame of FRAME_LEN sums, or a shorter frame closed by flush, into one wide accumulated total.
- Presents the total, item count and overflow flag on a held valid/ready output.
- Serves as the sequential benchmark harness stage that sits after the adder netlist.

---
 rtl/add8_pkg.sv | 17 +
 rtl/add8_accum_dp.sv | 57 +++++
 rtl/add8_sum_accum.sv | 82 ++++++++
 3 files changed

// File: rtl/add8_pkg.sv
// Shared types and constants for the add8 sum accumulator stage.
package add8_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 16;

  // Item counter must represent 0..frame_len inclusive.
  function automatic int cnt_width(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/add8_accum_dp.sv
// Accumulator datapath: acc/cnt/ovf registers, add with carry-out, clear/load.
module add8_accum_dp
  import add8_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  output logic [CNT_W-1:0]  o_cnt,
  output logic [ACC_W-1:0]  o_acc_nxt,
  output logic [CNT_W-1:0]  o_cnt_nxt,
  output logic              o_ovf_nxt
);

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [ACC_W:0]   w_add;

  assign w_add = {1'b0, r_acc} + (ACC_W + 1)'(i_data);
  assign o_cnt = r_cnt;

  // Post-update values; the top latches these into the result registers.
  always_comb begin
    o_acc_nxt = r_acc;
    o_cnt_nxt = r_cnt;
    o_ovf_nxt = r_ovf;
    if (i_load) begin
      o_acc_nxt = w_add[ACC_W-1:0];
      o_cnt_nxt = r_cnt + CNT_W'(1);
      o_ovf_nxt = r_ovf | w_add[ACC_W];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_clear) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_acc <= o_acc_nxt;
      r_cnt <= o_cnt_nxt;
      r_ovf <= o_ovf_nxt;
    end
  end

endmodule

// File: rtl/add8_sum_accum.sv
// Frames a valid/ready stream of adder sums into accumulated totals with a held result.
module add8_sum_accum
  import add8_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = cnt_width(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  state_e           r_state;
  logic             w_accept;
  logic             w_close;
  logic             w_clear;
  logic [CNT_W-1:0] w_cnt;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ovf_nxt;

  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == HOLD);
  assign w_accept  = in_valid & in_ready;
  assign w_clear   = out_valid & out_ready;

  // Flush only closes a non-empty frame; an item accepted alongside it counts.
  assign w_close = in_ready &
                   ((w_accept & (w_cnt_nxt == CNT_W'(FRAME_LEN))) |
                    (flush & ((w_cnt != '0) | w_accept)));

  add8_accum_dp #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_accept),
    .i_clear  (w_clear),
    .i_data   (in_data),
    .o_cnt    (w_cnt),
    .o_acc_nxt(w_acc_nxt),
    .o_cnt_nxt(w_cnt_nxt),
    .o_ovf_nxt(w_ovf_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ACCUM;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_close) begin
            r_state   <= HOLD;
            out_sum   <= w_acc_nxt;
            out_count <= w_cnt_nxt;
            out_ovf   <= w_ovf_nxt;
          end
        end
        HOLD: begin
          if (out_ready) r_state <= ACCUM;
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule
